// File: rtl/main_module_pkg.sv
// Shared constants for the menu/VGA block: 640x480@60 timing, band height,
// colour palette and button lane indices.
package main_module_pkg;

    // Horizontal timing, in pixel ticks
    localparam logic [9:0] H_ACTIVE     = 10'd640;
    localparam logic [9:0] H_FP         = 10'd16;
    localparam logic [9:0] H_SYNC       = 10'd96;
    localparam logic [9:0] H_BP         = 10'd48;
    localparam logic [9:0] H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam logic [9:0] H_SYNC_START = H_ACTIVE + H_FP;
    localparam logic [9:0] H_SYNC_END   = H_ACTIVE + H_FP + H_SYNC;

    // Vertical timing, in lines
    localparam logic [9:0] V_ACTIVE     = 10'd480;
    localparam logic [9:0] V_FP         = 10'd10;
    localparam logic [9:0] V_SYNC       = 10'd2;
    localparam logic [9:0] V_BP         = 10'd33;
    localparam logic [9:0] V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [9:0] V_SYNC_START = V_ACTIVE + V_FP;
    localparam logic [9:0] V_SYNC_END   = V_ACTIVE + V_FP + V_SYNC;

    // Each menu item owns a horizontal band of this many lines
    localparam logic [9:0] BAND_H = 10'd120;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam rgb_t COL_BLACK  = 24'h000000;
    localparam rgb_t COL_SEL    = 24'h00FF00;
    localparam rgb_t COL_CURSOR = 24'h0000FF;
    localparam rgb_t COL_BG     = 24'h404040;

    // Bit positions of the buttons inside the synchronizer vectors
    typedef enum logic [1:0] {
        BTN_UP   = 2'd0,
        BTN_DOWN = 2'd1,
        BTN_SEL  = 2'd2
    } btn_e;

    // Band number of a line (v / BAND_H); only lines below 525 occur
    function automatic logic [2:0] band_of(input logic [9:0] v);
        return 3'(v / BAND_H);
    endfunction

endpackage

// File: rtl/main_module_vga_timing.sv
// Pixel/line counters and raw sync/active decode for 640x480 VGA.
// Counters advance only on pixel ticks; decodes are combinational and the
// parent registers them.
module vga_timing
    import main_module_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    output logic [9:0] v,
    output logic       hsync_n,
    output logic       vsync_n,
    output logic       active
);

    logic [9:0] h_cnt;
    logic [9:0] v_cnt;

    // Raster scan: h wraps at end of line and steps v, v wraps at end of frame
    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (tick) begin
            if (h_cnt == H_TOTAL - 10'd1) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_TOTAL - 10'd1) ? '0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    assign v       = v_cnt;
    assign hsync_n = !(h_cnt >= H_SYNC_START && h_cnt < H_SYNC_END);
    assign vsync_n = !(v_cnt >= V_SYNC_START && v_cnt < V_SYNC_END);
    assign active  = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE);

endmodule

// File: rtl/main_module.sv
// Menu cursor/selection driven by three push buttons, rendered as coloured
// horizontal bands on a 640x480 VGA output.
// Optional feature: define MAIN_MODULE_DEBOUNCE_EN to require each
// synchronized button level to hold for DEBOUNCE_CYCLES clocks before use.
module main_module
    import main_module_pkg::*;
#(
    parameter int NUM_ITEMS       = 4,
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       up_btn,
    input  logic       down_btn,
    input  logic       select_btn,
    output logic       vga_hsync,
    output logic       vga_vsync,
    output logic       sync_blank,
    output logic       sync_b,
    output logic       clk_25,
    output logic [7:0] red,
    output logic [7:0] green,
    output logic [7:0] blue
);

    localparam logic [1:0] LAST = 2'(NUM_ITEMS - 1);

    if (NUM_ITEMS < 2 || NUM_ITEMS > 4 || DEBOUNCE_CYCLES < 1) begin : g_param_check
        $error("main_module: NUM_ITEMS must be 2..4 and DEBOUNCE_CYCLES >= 1");
    end

    logic [2:0] pins;
    logic [2:0] sync1, sync2, level, prev, pulse;
    logic [1:0] settle;
    logic [1:0] cursor, sel_idx, band_idx;
    logic       sel_valid;
    logic [2:0] band_raw;
    logic [9:0] v;
    logic       hsync_n, vsync_n, active;
    rgb_t       pix;

    assign pins = {select_btn, down_btn, up_btn};

    // Pixel clock divider; its high phase doubles as the pixel tick
    always_ff @(posedge clk) begin
        if (rst) clk_25 <= 1'b0;
        else     clk_25 <= ~clk_25;
    end

    vga_timing u_timing (
        .clk     (clk),
        .rst     (rst),
        .tick    (clk_25),
        .v       (v),
        .hsync_n (hsync_n),
        .vsync_n (vsync_n),
        .active  (active)
    );

    // Two-flop synchronizer plus edge register; idle level of the pins is 1
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '1;
            sync2 <= '1;
            prev  <= '1;
        end else begin
            sync1 <= pins;
            sync2 <= sync1;
            prev  <= level;
        end
    end

    // Mask edges while the reset-time 1s drain out of the synchronizer, so a
    // button already held low at reset release is not seen as a press
    always_ff @(posedge clk) begin
        if (rst)              settle <= 2'd3;
        else if (settle != 0) settle <= settle - 2'd1;
    end

`ifdef MAIN_MODULE_DEBOUNCE_EN
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    for (genvar i = 0; i < 3; i++) begin : g_db
        logic [DB_W-1:0] cnt;
        logic            lvl;

        // Accept a new level only after it differs for DEBOUNCE_CYCLES clocks
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt <= '0;
                lvl <= 1'b1;
            end else if (settle != 0) begin
                cnt <= '0;
                lvl <= sync2[i];
            end else if (sync2[i] == lvl) begin
                cnt <= '0;
            end else if (cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                cnt <= '0;
                lvl <= sync2[i];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end

        assign level[i] = lvl;
    end
`else
    assign level = sync2;
`endif

    assign pulse = prev & ~level & {3{settle == 2'd0}};

    // Cursor moves on up/down (ignored when both fire); select toggles or
    // retargets the selection using the cursor value before any move
    always_ff @(posedge clk) begin
        if (rst) begin
            cursor    <= '0;
            sel_valid <= 1'b0;
            sel_idx   <= '0;
        end else begin
            if (pulse[BTN_UP] && !pulse[BTN_DOWN])
                cursor <= (cursor == 2'd0) ? LAST : cursor - 2'd1;
            else if (pulse[BTN_DOWN] && !pulse[BTN_UP])
                cursor <= (cursor == LAST) ? 2'd0 : cursor + 2'd1;

            if (pulse[BTN_SEL]) begin
                if (sel_valid && sel_idx == cursor) begin
                    sel_valid <= 1'b0;
                end else begin
                    sel_valid <= 1'b1;
                    sel_idx   <= cursor;
                end
            end
        end
    end

    // Band colour: selection beats cursor beats background; black elsewhere
    always_comb begin
        band_raw = band_of(v);
        band_idx = (band_raw > 3'(LAST)) ? LAST : band_raw[1:0];
        pix      = COL_BLACK;
        if (active && band_raw < 3'(NUM_ITEMS)) begin
            if (sel_valid && band_idx == sel_idx) pix = COL_SEL;
            else if (band_idx == cursor)          pix = COL_CURSOR;
            else                                  pix = COL_BG;
        end
    end

    // Output register stage: one clock behind the counters
    always_ff @(posedge clk) begin
        if (rst) begin
            vga_hsync  <= 1'b1;
            vga_vsync  <= 1'b1;
            sync_blank <= 1'b0;
            red        <= '0;
            green      <= '0;
            blue       <= '0;
        end else begin
            vga_hsync  <= hsync_n;
            vga_vsync  <= vsync_n;
            sync_blank <= active;
            red        <= pix.r;
            green      <= pix.g;
            blue       <= pix.b;
        end
    end

    assign sync_b = 1'b0;

endmodule

// File: tb/tb_main_module.sv
// Scoreboard bench for main_module: stimulus pushes (edge, signal, value)
// expectations; a negedge monitor pops and compares them as edges arrive.
// Frame positions far from reset are reached by loading the raster counters.
module tb_main_module;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       up_btn = 1'b1, down_btn = 1'b1, select_btn = 1'b1;
    logic       vga_hsync, vga_vsync, sync_blank, sync_b, clk_25;
    logic [7:0] red, green, blue;

    main_module dut (
        .clk        (clk),
        .rst        (rst),
        .up_btn     (up_btn),
        .down_btn   (down_btn),
        .select_btn (select_btn),
        .vga_hsync  (vga_hsync),
        .vga_vsync  (vga_vsync),
        .sync_blank (sync_blank),
        .sync_b     (sync_b),
        .clk_25     (clk_25),
        .red        (red),
        .green      (green),
        .blue       (blue)
    );

    always #5 clk = ~clk;

    localparam int S_RGB = 0, S_HS = 1, S_VS = 2, S_BLANK = 3, S_CLK25 = 4, S_SYNCB = 5;

    typedef struct {
        int          at;
        int          sig;
        logic [23:0] exp;
        string       name;
    } exp_t;

    exp_t       sb[$];
    int         edge_n = 0;
    int         compared = 0;
    int         mismatched = 0;
    int         rel = 0;
    logic [9:0] fh, fv;

    always @(posedge clk) edge_n <= edge_n + 1;

    // Monitor: compare every expectation due at this edge
    always @(negedge clk) begin
        exp_t        it;
        logic [23:0] act;
        while (sb.size() > 0 && sb[0].at <= edge_n) begin
            it = sb.pop_front();
            case (it.sig)
                S_RGB:   act = {red, green, blue};
                S_HS:    act = {23'd0, vga_hsync};
                S_VS:    act = {23'd0, vga_vsync};
                S_BLANK: act = {23'd0, sync_blank};
                S_CLK25: act = {23'd0, clk_25};
                default: act = {23'd0, sync_b};
            endcase
            compared++;
            if (it.at != edge_n) begin
                mismatched++;
                $display("FAIL %s: not sampled at edge %0d (now %0d)", it.name, it.at, edge_n);
            end else if (act !== it.exp) begin
                mismatched++;
                $display("FAIL %s @edge %0d: got %h, want %h", it.name, edge_n, act, it.exp);
            end
        end
    end

    task automatic push(input int at, input int sig, input logic [23:0] e, input string nm);
        exp_t it;
        int   i;
        it = '{at, sig, e, nm};
        i  = sb.size();
        while (i > 0 && sb[i-1].at > at) i--;
        sb.insert(i, it);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Load the raster counters at an edge after which clk_25 is 0; the output
    // after edge j+1+2*d then shows the pixel d ticks past (hh, vv)
    task automatic jump(input int hh, input int vv, output int j);
        if (((edge_n - rel) % 2) != 0) step(1);
        j  = edge_n;
        fh = 10'(hh);
        fv = 10'(vv);
        force dut.u_timing.h_cnt = fh;
        force dut.u_timing.v_cnt = fv;
        #1;
        release dut.u_timing.h_cnt;
        release dut.u_timing.v_cnt;
    endtask

    // One-clock low pulse on the chosen pins; a = edge before the fall
    task automatic press(input bit u, input bit d, input bit s, output int a);
        a          = edge_n;
        up_btn     = ~u;
        down_btn   = ~d;
        select_btn = ~s;
        step(1);
        up_btn     = 1'b1;
        down_btn   = 1'b1;
        select_btn = 1'b1;
    endtask

    initial begin
        int j, a;

        // Reset values held while rst is high
        for (int k = 3; k <= 4; k++) begin
            push(k, S_CLK25, 24'h0, "rst_clk25");
            push(k, S_HS,    24'h1, "rst_hsync");
            push(k, S_VS,    24'h1, "rst_vsync");
            push(k, S_BLANK, 24'h0, "rst_blank");
            push(k, S_RGB,   24'h0, "rst_rgb");
            push(k, S_SYNCB, 24'h0, "rst_sync_b");
        end
        rst = 1'b1;
        step(5);
        rel = edge_n;
        rst = 1'b0;

        // First line after reset: pixel (h, 0) appears after edge rel+1+2h
        push(rel + 1, S_CLK25, 24'h1, "clk25_rise");
        push(rel + 2, S_CLK25, 24'h0, "clk25_fall");
        push(rel + 2, S_HS,    24'h1, "hsync_idle");
        push(rel + 2, S_VS,    24'h1, "vsync_idle");
        push(rel + 1, S_RGB,   24'h0000FF, "pix00_cursor");
        push(rel + 1, S_BLANK, 24'h1, "blank_h0");
        push(rel + 1 + 2*639, S_BLANK, 24'h1, "blank_h639");
        push(rel + 1 + 2*640, S_BLANK, 24'h0, "blank_h640");
        push(rel + 1 + 2*640, S_RGB,   24'h0, "rgb_h640");
        push(rel + 2 + 2*655, S_HS, 24'h1, "hsync_h655");
        push(rel + 1 + 2*656, S_HS, 24'h0, "hsync_h656");
        push(rel + 2 + 2*751, S_HS, 24'h0, "hsync_h751");
        push(rel + 1 + 2*752, S_HS, 24'h1, "hsync_h752");
        step(2*752 + 4);

        // Vertical sync around lines 490..491
        jump(799, 489, j);
        push(j + 1,          S_VS, 24'h1, "vsync_v489");
        push(j + 1 + 2,      S_VS, 24'h0, "vsync_v490");
        push(j + 1 + 2*1600, S_VS, 24'h0, "vsync_v491");
        push(j + 1 + 2*1601, S_VS, 24'h1, "vsync_v492");
        step(2*1601 + 4);

        // Up from cursor 0 wraps to the last item
        press(1, 0, 0, a);
        step(4);
        jump(0, 360, j);
        push(j + 1, S_RGB, 24'h0000FF, "up_band3_cursor");
        step(2);
        jump(0, 0, j);
        push(j + 1, S_RGB, 24'h404040, "up_band0_bg");
        step(2);

        // Three selects, 3 clocks apart, on the cursor band
        jump(0, 360, j);
        push(edge_n + 3, S_RGB, 24'h0000FF, "sel0_before");
        push(edge_n + 4, S_RGB, 24'h00FF00, "sel1_set");
        press(0, 0, 1, a);
        step(2);
        push(edge_n + 4, S_RGB, 24'h0000FF, "sel2_clear");
        press(0, 0, 1, a);
        step(2);
        push(edge_n + 4, S_RGB, 24'h00FF00, "sel3_set");
        press(0, 0, 1, a);
        step(8);

        // Up and down together: cursor stays on the last item
        press(1, 1, 0, a);
        step(5);
        jump(0, 240, j);
        push(j + 1, S_RGB, 24'h404040, "updown_band2");
        step(2);
        jump(0, 0, j);
        push(j + 1, S_RGB, 24'h404040, "updown_band0");
        step(2);

        // Down from the last item wraps to 0; selection unaffected
        press(0, 1, 0, a);
        step(5);
        jump(0, 0, j);
        push(j + 1, S_RGB, 24'h0000FF, "down_wrap_band0");
        step(2);
        jump(0, 360, j);
        push(j + 1, S_RGB, 24'h00FF00, "down_band3_sel");
        step(2);

        // Reset mid-frame with down held through release: no press results
        down_btn = 1'b0;
        rst      = 1'b1;
        step(3);
        push(edge_n, S_HS, 24'h1, "rst2_hsync");
        rel = edge_n;
        rst = 1'b0;
        push(rel + 1, S_RGB, 24'h0000FF, "rst2_pix0");
        push(rel + 6, S_RGB, 24'h0000FF, "held_no_press");
        step(8);
        down_btn = 1'b1;
        step(4);
        jump(0, 360, j);
        push(j + 1, S_RGB, 24'h404040, "rst2_sel_cleared");
        step(2);

        for (int i = 0; i < 50 && sb.size() > 0; i++) step(1);
        while (sb.size() > 0) begin
            exp_t it;
            it = sb.pop_front();
            compared++;
            mismatched++;
            $display("FAIL %s: never sampled, want %h at edge %0d", it.name, it.exp, it.at);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/main_module.md
MAIN_MODULE -- requirements
Module: main_module

Interface
REQ-001 SHALL have parameter NUM_ITEMS, default 4, which is the number of menu items; the legal range is 2..4.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 65536, which is the number of stable clk cycles required before a button is accepted (used only when the macro is defined).
REQ-003 SHALL have port clk, input, 1 bit: the 50 MHz system clock and the only clock.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have ports up_btn, down_btn and select_btn, each input, 1 bit: asynchronous push buttons, active-low, idle high.
REQ-006 SHALL have ports vga_hsync and vga_vsync, each output, 1 bit: VGA sync signals, active-low.
REQ-007 SHALL have port sync_blank, output, 1 bit: DAC BLANK_n; it is high during the active video region.
REQ-008 SHALL have port sync_b, output, 1 bit: DAC SYNC_n; it is tied to constant 0.
REQ-009 SHALL have port clk_25, output, 1 bit: the 25 MHz pixel clock, equal to clk divided by 2.
REQ-010 SHALL have ports red, green and blue, each output, 8 bits: pixel colour.

Function
REQ-011 SHALL toggle the register driving clk_25 on every clk rising edge; the pixel tick is the cycle in which clk_25 is 1.
REQ-012 SHALL run the horizontal counter 0..799 and the vertical counter 0..524, advancing only on a pixel tick.
REQ-013 SHALL wrap the horizontal counter from 799 to 0 and increment the vertical counter on that wrap; the vertical counter wraps from 524 to 0.
REQ-014 SHALL drive vga_hsync low for h in 656..751 and vga_vsync low for v in 490..491.
REQ-015 SHALL define the active region as h<640 and v<480; sync_blank is 1 only inside it.
REQ-016 SHALL register all video outputs, giving one clk of latency from the counters to the pins.
REQ-017 SHALL pass each button through a 2-flop synchronizer and then a falling-edge detector, producing a one-cycle press pulse.
REQ-018 SHALL accept a low level that lasts a single clk cycle as a press.
REQ-019 SHALL update the cursor (range 0..NUM_ITEMS-1) on an up pulse by decrementing it, wrapping 0 to NUM_ITEMS-1.
REQ-020 SHALL update the cursor on a down pulse by incrementing it, wrapping NUM_ITEMS-1 to 0.
REQ-021 SHALL ignore up and down pulses that occur in the same cycle; neither is applied.
REQ-022 SHALL hold the selection as sel_valid plus sel_idx and update it on a select pulse.
REQ-023 SHALL, on a select pulse, clear sel_valid if sel_valid=1 and sel_idx equals the cursor; otherwise it sets sel_valid=1 and sel_idx to the cursor.
REQ-024 SHALL evaluate a select pulse against the pre-update cursor value when it coincides with an up or down pulse.
REQ-025 SHALL apply a pin press to the state 3 clk cycles after the pin falls (2 synchronizer cycles plus 1 edge cycle).
REQ-026 SHALL compute the pixel band as v/120 and clamp it to NUM_ITEMS-1.
REQ-027 SHALL colour a band whose index is at or above NUM_ITEMS 000000.
REQ-028 SHALL use the following colour priority in the active region:
- the selected band (sel_valid=1 and band equals sel_idx) is 00FF00;
- otherwise the cursor band is 0000FF;
- otherwise the band is 404040.
REQ-029 SHALL drive red, green and blue to 0 outside the active region.

Reset
REQ-030 SHALL, while rst=1 at a clk edge, set clk_25=0, h=0, v=0, cursor=0, sel_valid=0, sel_idx=0, the synchronizers to 1 and the edge registers to 1.
REQ-031 SHALL hold the outputs in reset at vga_hsync=1, vga_vsync=1, sync_blank=0, sync_b=0 and red/green/blue=0.
REQ-032 SHALL, if reset is asserted mid-frame or mid-press, abandon the state immediately; a button held low through reset release produces no pulse.

Configuration
REQ-033 SHALL, when the macro MAIN_MODULE_DEBOUNCE_EN is defined, require each synchronized button to stay stable for DEBOUNCE_CYCLES clk cycles before the falling edge is taken; shorter glitches are ignored.
REQ-034 SHALL, when MAIN_MODULE_DEBOUNCE_EN is not defined, perform no debounce and behave exactly as REQ-017 and REQ-018.

Structure
REQ-035 SHALL place the timing constants (640/16/96/48, 480/10/2/33, totals 800/525), the band height of 120 and the colour constants in package main_module_pkg.
REQ-036 SHALL implement the counters and sync generation in one sub-module, vga_timing, instantiated once.

Verification
REQ-037 SHALL cover reset release: after 2 clk cycles, clk_25 reads 0 then 1, and hsync=1, vsync=1 and red/green/blue=00.
REQ-038 SHALL cover an up_btn low for 1 cycle from cursor=0: the cursor becomes 3 and band 3 (v=360..479) shows blue=FF.
REQ-039 SHALL cover, after that up press, three 1-cycle select presses spaced 3 cycles apart: sel_valid goes 1, 0, 1; band 3 shows green=FF, then blue=FF, then green=FF.
REQ-040 SHALL cover a pixel at h=0, v=0 after reset with no presses: it shows 0000FF, and h=639 to h=640 takes sync_blank from 1 to 0.
REQ-041 SHALL cover hsync over a full line: hsync is low for exactly 96 pixel ticks (192 clk cycles) starting at h=656, and vsync is low for v=490..491.
REQ-042 SHALL cover up_btn and down_btn falling in the same cycle: the cursor is unchanged.
